// File: rtl/insn_prefetch_queue.sv
// Instruction prefetch queue: issues one imem read per cycle from fetch_pc, buffers
// returned {insn, pc} pairs and hands them to decode over a valid/ready handshake.
module insn_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] address_imem,
    input  logic [31:0] q_imem,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_insn,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Handshake: decode takes the head on a cycle where out_valid && out_ready;
    // out_valid never depends on out_ready, and the head is held until taken.

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   mem_insn [DEPTH];
    logic [31:0]   mem_pc   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    // Credit counts the read still in flight, so the FIFO can never overflow.
    // Pops in the same cycle deliberately do not free credit.
    assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue     = (occupancy < DEPTH_W) && !redirect;
    assign push      = inflight && !redirect;
    assign pop       = out_valid && out_ready;

    assign address_imem = fetch_pc;
    assign out_valid    = (count != '0) && !redirect;
    assign out_insn     = mem_insn[rd_ptr];
    assign out_pc       = mem_pc[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc    <= redirect_pc;
            inflight    <= 1'b0;
        end else if (issue) begin
            fetch_pc    <= fetch_pc + 32'd1;
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
        end else begin
            inflight    <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero until first written.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_insn[i] <= '0;
                mem_pc[i]   <= '0;
            end
        end else if (push) begin
            mem_insn[wr_ptr] <= q_imem;
            mem_pc[wr_ptr]   <= inflight_pc;
        end
    end

    assert property (@(posedge clock) disable iff (!reset) occupancy <= DEPTH_W);

endmodule
